// File: rtl/l1_l2_request_arbiter.sv
// Round-robin arbiter sharing the single L1->L2 request channel between the
// instruction and data caches, one outstanding transaction at a time.
module l1_l2_request_arbiter #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int BYTE_SELECT_WIDTH = 6,
  parameter int LINE_WIDTH        = 512,
  parameter int WDATA_WIDTH       = 32,
  parameter int STAT_WIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     i_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  output logic                     i_req_ready,
  output logic                     i_resp_valid,
  output logic [LINE_WIDTH-1:0]    i_resp_data,

  input  logic                     d_req_valid,
  input  logic                     d_req_write,
  input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
  input  logic [WDATA_WIDTH-1:0]   d_req_wdata,
  output logic                     d_req_ready,
  output logic                     d_resp_valid,
  output logic [LINE_WIDTH-1:0]    d_resp_data,

  output logic                     l2_req_valid,
  input  logic                     l2_req_ready,
  output logic [ADDRESS_WIDTH-1:0] l2_req_addr,
  output logic                     l2_req_write,
  output logic [WDATA_WIDTH-1:0]   l2_req_wdata,
  output logic                     l2_req_src,
  input  logic                     l2_resp_valid,
  input  logic [LINE_WIDTH-1:0]    l2_resp_data,

  input  logic                     stat_clear,
  output logic [STAT_WIDTH-1:0]    stat_i_grants,
  output logic [STAT_WIDTH-1:0]    stat_d_grants,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                     favour_i;
  logic                     grant_i;
  logic                     grant_d;
  logic [ADDRESS_WIDTH-1:0] cap_addr;
  logic                     cap_write;
  logic [WDATA_WIDTH-1:0]   cap_wdata;
  logic                     cap_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_next = ISSUE;
      ISSUE:   if (l2_req_ready)       state_next = WAIT;
      WAIT:    if (l2_resp_valid)      state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Grants are gated by rst_n so no ready escapes while reset is held.
  always_comb begin
    grant_d      = rst_n && (state == IDLE) && d_req_valid && (!i_req_valid || !favour_i);
    grant_i      = rst_n && (state == IDLE) && i_req_valid && (!d_req_valid || favour_i);
    d_req_ready  = grant_d;
    i_req_ready  = grant_i;
    l2_req_valid = (state == ISSUE);
    busy         = (state != IDLE);
    l2_req_addr  = cap_write ? cap_addr
                             : {cap_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH], {BYTE_SELECT_WIDTH{1'b0}}};
    l2_req_write = cap_write;
    l2_req_wdata = cap_wdata;
    l2_req_src   = cap_src;
  end

  // Pointer always favours the requester that was not granted last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      favour_i  <= 1'b0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_src   <= 1'b0;
    end else if (grant_d) begin
      favour_i  <= 1'b1;
      cap_addr  <= d_req_addr;
      cap_write <= d_req_write;
      cap_wdata <= d_req_wdata;
      cap_src   <= 1'b0;
    end else if (grant_i) begin
      favour_i  <= 1'b0;
      cap_addr  <= i_req_addr;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_src   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if ((state == WAIT) && l2_resp_valid) begin
        if (cap_src) begin
          i_resp_valid <= 1'b1;
          i_resp_data  <= l2_resp_data;
        end else begin
          d_resp_valid <= 1'b1;
          d_resp_data  <= l2_resp_data;
        end
      end
    end
  end

  // Clear takes priority over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
    end else if (stat_clear) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
    end else begin
      if (grant_i && (stat_i_grants != '1)) stat_i_grants <= stat_i_grants + STAT_WIDTH'(1);
      if (grant_d && (stat_d_grants != '1)) stat_d_grants <= stat_d_grants + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// Directed bench for l1_l2_request_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_l1_l2_request_arbiter;

  localparam int AW  = 32;
  localparam int BSW = 6;
  localparam int LW  = 512;
  localparam int WW  = 32;
  // Narrow counters keep the saturation run short.
  localparam int SW  = 8;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_resp_valid;
  logic [LW-1:0] i_resp_data;
  logic          d_req_valid;
  logic          d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [WW-1:0] d_req_wdata;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [LW-1:0] d_resp_data;
  logic          l2_req_valid;
  logic          l2_req_ready  = 1'b0;
  logic [AW-1:0] l2_req_addr;
  logic          l2_req_write;
  logic [WW-1:0] l2_req_wdata;
  logic          l2_req_src;
  logic          l2_resp_valid = 1'b0;
  logic [LW-1:0] l2_resp_data  = '0;
  logic          stat_clear;
  logic [SW-1:0] stat_i_grants;
  logic [SW-1:0] stat_d_grants;
  logic          busy;

  l1_l2_request_arbiter #(
    .ADDRESS_WIDTH(AW), .BYTE_SELECT_WIDTH(BSW), .LINE_WIDTH(LW),
    .WDATA_WIDTH(WW), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
    .l2_req_write(l2_req_write), .l2_req_wdata(l2_req_wdata), .l2_req_src(l2_req_src),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .stat_clear(stat_clear), .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, LW'(actual), LW'(expected));
  endtask

  task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkOutput(name, LW'(actual), LW'(expected));
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // L2 responder: ready after l2_ready_lat stalled cycles, response l2_resp_lat cycles later.
  int         l2_ready_lat  = 0;
  int         l2_resp_lat   = 0;
  logic [7:0] l2_pattern    = 8'h11;
  int         spurious_req  = 0;
  int         spurious_done = 0;
  int         rsp_ready_wait = 0;
  int         rsp_resp_wait  = 0;
  bit         rsp_pending    = 1'b0;

  initial begin : l2_responder
    forever begin
      @(negedge clk);
      #1;
      l2_resp_valid = 1'b0;
      if (rsp_pending) begin
        if (rsp_resp_wait == 0) begin
          l2_resp_valid = 1'b1;
          l2_resp_data  = {64{l2_pattern}};
          rsp_pending   = 1'b0;
        end else begin
          rsp_resp_wait--;
        end
      end else if (spurious_done != spurious_req) begin
        l2_resp_valid = 1'b1;
        l2_resp_data  = {64{8'h3C}};
        spurious_done = spurious_req;
      end
      if (l2_req_valid && !rsp_pending) begin
        if (rsp_ready_wait >= l2_ready_lat) begin
          l2_req_ready   = 1'b1;
          rsp_pending    = 1'b1;
          rsp_resp_wait  = l2_resp_lat;
          rsp_ready_wait = 0;
        end else begin
          l2_req_ready = 1'b0;
          rsp_ready_wait++;
        end
      end else begin
        l2_req_ready = 1'b0;
      end
    end
  end

  // Transaction-level model: one outstanding record, last-granted side, counters.
  bit            m_valid  = 1'b0;
  bit            m_txn    = 1'b0;
  bit            m_issued = 1'b0;
  bit            m_src    = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  bit            m_write  = 1'b0;
  logic [WW-1:0] m_wdata  = '0;
  bit            m_last_i = 1'b1;
  int            m_cnt_i  = 0;
  int            m_cnt_d  = 0;
  bit            m_rv_i   = 1'b0;
  bit            m_rv_d   = 1'b0;
  logic [LW-1:0] m_data_i = '0;
  logic [LW-1:0] m_data_d = '0;
  bit            exp_gd;
  bit            exp_gi;

  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      exp_gd = rst_n && !m_txn && d_req_valid && (!i_req_valid || m_last_i);
      exp_gi = rst_n && !m_txn && i_req_valid && (!d_req_valid || !m_last_i);
      if (m_valid) begin
        checkBit("d_req_ready", d_req_ready, exp_gd);
        checkBit("i_req_ready", i_req_ready, exp_gi);
        checkBit("busy", busy, m_txn);
        checkBit("l2_req_valid", l2_req_valid, m_txn && !m_issued);
        if (m_txn && !m_issued) begin
          checkWord("l2_req_addr", l2_req_addr, m_write ? m_addr : {m_addr[AW-1:BSW], 6'b0});
          checkBit("l2_req_write", l2_req_write, m_write);
          checkBit("l2_req_src", l2_req_src, m_src);
          if (m_write) checkWord("l2_req_wdata", l2_req_wdata, m_wdata);
        end
        checkBit("i_resp_valid", i_resp_valid, m_rv_i);
        checkBit("d_resp_valid", d_resp_valid, m_rv_d);
        checkOutput("i_resp_data", i_resp_data, m_data_i);
        checkOutput("d_resp_data", d_resp_data, m_data_d);
        checkWord("stat_i_grants", 32'(stat_i_grants), 32'(m_cnt_i));
        checkWord("stat_d_grants", 32'(stat_d_grants), 32'(m_cnt_d));
      end
      if (!rst_n) begin
        m_valid  = 1'b1;
        m_txn    = 1'b0;
        m_issued = 1'b0;
        m_src    = 1'b0;
        m_addr   = '0;
        m_write  = 1'b0;
        m_wdata  = '0;
        m_last_i = 1'b1;
        m_cnt_i  = 0;
        m_cnt_d  = 0;
        m_rv_i   = 1'b0;
        m_rv_d   = 1'b0;
        m_data_i = '0;
        m_data_d = '0;
      end else if (m_valid) begin
        m_rv_i = 1'b0;
        m_rv_d = 1'b0;
        if (m_txn && m_issued) begin
          if (l2_resp_valid) begin
            if (m_src) begin
              m_rv_i   = 1'b1;
              m_data_i = l2_resp_data;
            end else begin
              m_rv_d   = 1'b1;
              m_data_d = l2_resp_data;
            end
            m_txn = 1'b0;
          end
        end else if (m_txn) begin
          if (l2_req_ready) m_issued = 1'b1;
        end else if (exp_gd || exp_gi) begin
          m_txn    = 1'b1;
          m_issued = 1'b0;
          m_src    = exp_gi;
          m_addr   = exp_gi ? i_req_addr : d_req_addr;
          m_write  = exp_gd && d_req_write;
          m_wdata  = d_req_wdata;
          m_last_i = exp_gi;
          if (exp_gi) m_cnt_i = (m_cnt_i < STAT_MAX) ? m_cnt_i + 1 : STAT_MAX;
          else        m_cnt_d = (m_cnt_d < STAT_MAX) ? m_cnt_d + 1 : STAT_MAX;
        end
        if (stat_clear) begin
          m_cnt_i = 0;
          m_cnt_d = 0;
        end
      end
    end
  end

  // Drives one cycle of requester inputs, then returns at that cycle's sample point.
  task automatic applyStimulus(input logic rst, input logic dv, input logic dw,
                               input logic [AW-1:0] da, input logic [WW-1:0] dwd,
                               input logic iv, input logic [AW-1:0] ia, input logic sc);
    @(posedge clk);
    #1;
    rst_n       = rst;
    d_req_valid = dv;
    d_req_write = dw;
    d_req_addr  = da;
    d_req_wdata = dwd;
    i_req_valid = iv;
    i_req_addr  = ia;
    stat_clear  = sc;
    #6;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #7;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return d_req_ready;
      1:       return i_req_ready;
      2:       return d_resp_valid;
      3:       return i_resp_valid;
      default: return !busy;
    endcase
  endfunction

  task automatic pollSignal(input int which, input int max_cycles, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      if (sel(which)) begin
        ok = 1'b1;
        break;
      end
      waitCycle();
    end
    if (!ok) timeoutFail(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit            rec [6];
    bit            exp_seq [6];
    int            n;
    int            count;
    logic [LW-1:0] pat;

    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_n       = 1'b0;
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 32'h0000_1000;
    d_req_wdata = '0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_2040;
    stat_clear  = 1'b0;

    // Reset with both requesters valid; data wins first, instruction next.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, 32'h0000_2040, 1'b0);
    checkBit("rst_d_ready", d_req_ready, 1'b0);
    checkBit("rst_i_ready", i_req_ready, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_l2_req_valid", l2_req_valid, 1'b0);
    checkWord("rst_stat_d", 32'(stat_d_grants), 32'd0);
    checkWord("rst_stat_i", 32'(stat_i_grants), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, 32'h0000_2040, 1'b0);
    checkBit("first_d_ready", d_req_ready, 1'b1);
    checkBit("first_i_ready", i_req_ready, 1'b0);
    waitCycle();
    pollSignal(1, 20, "wait_i_grant");
    checkWord("t1_stat_d_mid", 32'(stat_d_grants), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    pollSignal(4, 20, "t1_idle");
    checkWord("t1_stat_d", 32'(stat_d_grants), 32'd1);
    checkWord("t1_stat_i", 32'(stat_i_grants), 32'd1);

    // Data read: line-aligned address, single response pulse.
    l2_pattern = 8'hA5; l2_ready_lat = 0; l2_resp_lat = 2;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h1234_5678, '0, 1'b0, '0, 1'b0);
    checkBit("rd_d_ready", d_req_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkBit("rd_l2_valid", l2_req_valid, 1'b1);
    checkWord("rd_l2_addr", l2_req_addr, 32'h1234_5640);
    checkBit("rd_l2_src", l2_req_src, 1'b0);
    checkBit("rd_l2_write", l2_req_write, 1'b0);
    pollSignal(2, 20, "rd_resp");
    pat = {64{8'hA5}};
    checkOutput("rd_resp_data", d_resp_data, pat);
    checkBit("rd_i_resp_quiet", i_resp_valid, 1'b0);
    waitCycle();
    checkBit("rd_resp_single", d_resp_valid, 1'b0);

    // Write-through with L2 stalling: fields held for five cycles.
    l2_ready_lat = 4; l2_resp_lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_007F, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    checkBit("wr_d_ready", d_req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      else        waitCycle();
      checkBit("wr_l2_valid", l2_req_valid, 1'b1);
      checkWord("wr_l2_addr", l2_req_addr, 32'h0000_007F);
      checkBit("wr_l2_write", l2_req_write, 1'b1);
      checkWord("wr_l2_wdata", l2_req_wdata, 32'hDEAD_BEEF);
    end
    waitCycle();
    checkBit("wr_l2_valid_drop", l2_req_valid, 1'b0);
    pollSignal(2, 20, "wr_ack");
    l2_ready_lat = 0; l2_resp_lat = 0; l2_pattern = 8'h11;

    // Fresh reset, then both continuously valid: D,I,D,I,D,I.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0, 1'b1, 32'h0000_6000, 1'b0);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      if (d_req_ready)      begin rec[n] = 1'b0; n++; end
      else if (i_req_ready) begin rec[n] = 1'b1; n++; end
      if (n < 6) waitCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    if (n < 6) timeoutFail("rr_grants");
    for (int k = 0; k < n; k++) checkBit("rr_order", rec[k], exp_seq[k]);
    pollSignal(4, 20, "rr_idle");
    checkWord("rr_stat_d", 32'(stat_d_grants), 32'd3);
    checkWord("rr_stat_i", 32'(stat_i_grants), 32'd3);
    spurious_req++;
    for (int k = 0; k < 4; k++) begin
      waitCycle();
      checkBit("spur_d_resp", d_resp_valid, 1'b0);
      checkBit("spur_i_resp", i_resp_valid, 1'b0);
      checkBit("spur_busy", busy, 1'b0);
    end

    // Saturation of the instruction counter, then clear racing a grant.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_7000, 1'b0);
    count = 0;
    for (int cyc = 0; cyc < 2000 && count < STAT_MAX + 5; cyc++) begin
      if (i_req_ready) count++;
      waitCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    if (count < STAT_MAX + 5) timeoutFail("sat_grants");
    pollSignal(4, 20, "sat_idle");
    checkWord("sat_stat_i", 32'(stat_i_grants), 32'(STAT_MAX));
    checkWord("sat_stat_d", 32'(stat_d_grants), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_7000, 1'b1);
    checkBit("clr_i_ready", i_req_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkWord("clr_stat_i", 32'(stat_i_grants), 32'd0);
    checkWord("clr_stat_d", 32'(stat_d_grants), 32'd0);
    pollSignal(4, 20, "clr_idle");

    // Reset during WAIT; the stale response arrives after release and is dropped.
    l2_pattern = 8'hEE; l2_ready_lat = 0; l2_resp_lat = 6;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3000, '0, 1'b0, '0, 1'b0);
    checkBit("mid_d_ready", d_req_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    waitCycle();
    checkBit("mid_busy_wait", busy, 1'b1);
    checkBit("mid_l2_valid_wait", l2_req_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkBit("mid_busy_rst", busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      waitCycle();
      checkBit("stale_d_resp", d_resp_valid, 1'b0);
      checkBit("stale_i_resp", i_resp_valid, 1'b0);
      checkBit("stale_busy", busy, 1'b0);
    end
    l2_pattern = 8'h5A; l2_resp_lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_4444, 1'b0);
    checkBit("post_i_ready", i_req_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkWord("post_l2_addr", l2_req_addr, 32'h0000_4440);
    checkBit("post_l2_src", l2_req_src, 1'b1);
    checkBit("post_l2_write", l2_req_write, 1'b0);
    pollSignal(3, 20, "post_resp");
    pat = {64{8'h5A}};
    checkOutput("post_resp_data", i_resp_data, pat);
    checkBit("post_d_resp_quiet", d_resp_valid, 1'b0);

    for (int k = 0; k < 3; k++) waitCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_l2_request_arbiter.md
Name: l1_l2_request_arbiter

Overview:
- Shares the single L1-to-L2 request channel between the split L1 instruction cache (read misses) and the L1 data cache (read misses and write-throughs).
- Accepts one request at a time, issues it to L2, waits for the L2 response, and routes the response back to the requester that owns the transaction.
- Keeps saturating per-requester grant counters for the statistics report.

Parameters:
ADDRESS_WIDTH, 32, byte address width (tag 12 / index 14 / byte select 6)
BYTE_SELECT_WIDTH, 6, line offset bits; a 64-byte line
LINE_WIDTH, 512, L2 response line width in bits
WDATA_WIDTH, 32, data cache write-through word width
STAT_WIDTH, 16, width of each grant counter

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
i_req_valid  in  1  instruction cache read-miss request
i_req_addr  in  ADDRESS_WIDTH  instruction miss address
i_req_ready  out  1  instruction request accepted this cycle
i_resp_valid  out  1  one-cycle pulse: line for instruction cache
i_resp_data  out  LINE_WIDTH  returned line
d_req_valid  in  1  data cache request
d_req_write  in  1  1 = write-through, 0 = read miss
d_req_addr  in  ADDRESS_WIDTH  data request address
d_req_wdata  in  WDATA_WIDTH  write-through data
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  one-cycle pulse: read line or write acknowledge
d_resp_data  out  LINE_WIDTH  returned line (don't-care for writes)
l2_req_valid  out  1  request to L2
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  ADDRESS_WIDTH  L2 address
l2_req_write  out  1  write-through flag
l2_req_wdata  out  WDATA_WIDTH  write data
l2_req_src  out  1  0 = data cache, 1 = instruction cache
l2_resp_valid  in  1  L2 response / write acknowledge
l2_resp_data  in  LINE_WIDTH  L2 line data
stat_clear  in  1  synchronous clear of the grant counters
stat_i_grants  out  STAT_WIDTH  instruction grants, saturating
stat_d_grants  out  STAT_WIDTH  data grants, saturating
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - State goes to IDLE and the round-robin pointer is set to favour the data cache.
  - All outputs return to 0: readies, resp_valids, resp_data, l2_req_*, stat counters, busy.
  - A transaction in flight is dropped. A later l2_resp_valid for it is ignored because the state is IDLE.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Only one valid request: grant it.
  - Both valid: grant the requester not granted last (round-robin). Ties right after reset go to the data cache.
  - The grant is signalled by a combinational X_req_ready = (state == IDLE) && selected. It is never high outside IDLE, and never high for both requesters.
  - On grant, capture addr, write, wdata and the source, bump the counter, flip the pointer, and go to ISSUE.
- ISSUE:
  - l2_req_valid = 1, with fields driven from the captured registers and held stable.
  - Go to WAIT on the cycle l2_req_ready = 1.
  - Read requests use l2_req_addr = captured address with [BYTE_SELECT_WIDTH-1:0] forced to 0. Writes forward the full address.
  - Instruction requests always drive l2_req_write = 0.
- WAIT:
  - l2_req_valid = 0.
  - On l2_resp_valid, register l2_resp_data into the owner's resp_data, pulse the owner's resp_valid in the next cycle (exactly one cycle), and go to IDLE.
- l2_resp_valid in IDLE or ISSUE is ignored.
- Latency:
  - Grant at cycle T puts l2_req_valid high at T+1.
  - If l2_req_ready is already high, WAIT is entered at T+2.
  - With l2_resp_valid at cycle R, resp_valid is high at R+1.
  - The arbiter is back in IDLE at R+1 and may grant a new request in that same cycle.
- Requesters hold valid, addr, write and wdata stable until ready. A request that drops valid before ready is simply not taken.
- resp_data holds its last value between pulses. The non-owner's resp_valid stays 0.
- Counters:
  - Increment by 1 per grant and saturate at all-ones (0xFFFF at default width).
  - stat_clear forces both counters to 0. If stat_clear and a grant occur in the same cycle, the result is 0 (clear wins).
- Only one transaction is outstanding at a time; there is no queueing in the arbiter.

Test Plan:
- Reset with both requests valid, then release rst_n → d_req_ready high in the first IDLE cycle. i_req_ready stays low until the data transaction completes, then goes high. stat_d_grants=1, stat_i_grants=1.
- Data read at d_req_addr=0x1234_5678, l2_req_ready tied 1, l2_resp_valid 3 cycles after issue with data 0xA5 replicated → l2_req_addr=0x1234_5640, l2_req_src=0, l2_req_write=0. d_resp_valid is a single pulse one cycle after l2_resp_valid, with d_resp_data = 0xA5 pattern.
- Data write-through at addr 0x0000_007F, wdata=0xDEAD_BEEF, l2_req_ready held low 4 cycles → l2_req_valid high and fields stable for 5 cycles. l2_req_addr=0x0000_007F, l2_req_write=1. d_resp_valid pulses after the acknowledge.
- Both requesters continuously valid for 6 transactions → grants alternate D,I,D,I,D,I and both counters read 3. Inject a spurious l2_resp_valid in IDLE → no resp pulse and no state change.
- Counters preloaded near 0xFFFF (run 65540 instruction grants) → stat_i_grants stays 0xFFFF. stat_clear asserted in the same cycle as a grant → counter reads 0.
- Assert rst_n=0 during WAIT, then deliver l2_resp_valid after release → no i_resp_valid or d_resp_valid pulse, busy=0, and the next request is serviced normally.
